// File: rtl/ps_ctrl_regs_if.sv
// ps_ctrl_regs_if: AXI4-Lite control port between the PS (master) and ps_ctrl_regs (slave).
//   aw*/w*/b* : write address, write data and write response channels
//   ar*/r*    : read address and read data channels
interface ps_ctrl_regs_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ps_ctrl_regs.sv
// ps_ctrl_regs: AXI4-Lite control-register slave in front of the accelerator core.
// Holds the launch configuration, pulses core_start, tracks done/idle and drives
// the level interrupt.
//   clk, rst_n       : clock, asynchronous active-low reset
//   s_axi_control    : AXI4-Lite slave port (ps_ctrl_regs_if.slave)
//   core_start       : one-cycle launch pulse to the core
//   core_done        : one-cycle completion pulse from the core
//   core_idle        : core idle level
//   cfg_instr_addr   : instruction stream base byte address
//   cfg_instr_num    : instruction count
//   interrupt        : level interrupt (GIE & ISR, registered)
// Build option: define PS_CTRL_IRQ_EN to implement GIE/IER/ISR and the interrupt;
// otherwise those registers read 0 and interrupt is tied low.
module ps_ctrl_regs #(
  parameter int unsigned PS_CTRL_AXI_ADDR_WIDTH = 12,
  parameter int unsigned PS_CTRL_AXI_DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  ps_ctrl_regs_if.slave s_axi_control,
  output logic          core_start,
  input  logic          core_done,
  input  logic          core_idle,
  output logic [63:0]   cfg_instr_addr,
  output logic [31:0]   cfg_instr_num,
  output logic          interrupt
);
  localparam int unsigned DATA_W  = PS_CTRL_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned IDX_LSB = 2;

  localparam logic [IDX_W-1:0] REG_CTRL    = 4'd0;
  localparam logic [IDX_W-1:0] REG_GIE     = 4'd1;
  localparam logic [IDX_W-1:0] REG_IER     = 4'd2;
  localparam logic [IDX_W-1:0] REG_ISR     = 4'd3;
  localparam logic [IDX_W-1:0] REG_ADDR_LO = 4'd4;
  localparam logic [IDX_W-1:0] REG_ADDR_HI = 4'd5;
  localparam logic [IDX_W-1:0] REG_NUM     = 4'd6;

  typedef enum logic {W_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_word_c;
  logic              done_q, done_d, start_req_q, start_req_d, core_start_q, core_start_d;
  logic [DATA_W-1:0] addr_lo_q, addr_lo_d, addr_hi_q, addr_hi_d, num_q, num_d;
`ifdef PS_CTRL_IRQ_EN
  logic              gie_q, gie_d, ier_q, ier_d, isr_q, isr_d, irq_q, irq_d;
`endif

  logic              aw_fire_c, w_fire_c, b_fire_c, ar_fire_c, r_fire_c, wr_en_c;
  logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [STRB_W-1:0] wr_strb_c;
  logic [PS_CTRL_AXI_ADDR_WIDTH-1:0] unused_addr;

  // Only address bits [5:2] are decoded.
  assign unused_addr = s_axi_control.awaddr ^ s_axi_control.araddr;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign aw_fire_c = s_axi_control.awvalid & awready_q;
  assign w_fire_c  = s_axi_control.wvalid & wready_q;
  assign b_fire_c  = bvalid_q & s_axi_control.bready;
  assign ar_fire_c = s_axi_control.arvalid & arready_q;
  assign r_fire_c  = rvalid_q & s_axi_control.rready;

  // A beat arriving this cycle bypasses its holding register.
  assign wr_idx_c  = aw_fire_c ? s_axi_control.awaddr[IDX_LSB +: IDX_W] : aw_idx_q;
  assign wr_data_c = w_fire_c ? s_axi_control.wdata : wdata_q;
  assign wr_strb_c = w_fire_c ? s_axi_control.wstrb : wstrb_q;
  assign wr_en_c   = (w_state_q == W_ADDR) & (aw_held_q | aw_fire_c) & (w_held_q | w_fire_c);
  assign rd_idx_c  = s_axi_control.araddr[IDX_LSB +: IDX_W];

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_ADDR;
      r_state_q <= R_ADDR;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Next-state logic for both channel FSMs.
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_ADDR: if (wr_en_c)  w_state_d = W_RESP;
      W_RESP: if (b_fire_c) w_state_d = W_ADDR;
    endcase
    case (r_state_q)
      R_ADDR: if (ar_fire_c) r_state_d = R_DATA;
      R_DATA: if (r_fire_c)  r_state_d = R_ADDR;
    endcase
  end

  // Read data mux.
  always_comb begin
    rd_word_c = '0;
    case (rd_idx_c)
      REG_CTRL:    rd_word_c = DATA_W'({core_idle, done_q, start_req_q | core_start_q});
`ifdef PS_CTRL_IRQ_EN
      REG_GIE:     rd_word_c = DATA_W'(gie_q);
      REG_IER:     rd_word_c = DATA_W'(ier_q);
      REG_ISR:     rd_word_c = DATA_W'(isr_q);
`endif
      REG_ADDR_LO: rd_word_c = addr_lo_q;
      REG_ADDR_HI: rd_word_c = addr_hi_q;
      REG_NUM:     rd_word_c = num_q;
      default:     rd_word_c = '0;
    endcase
  end

  // Handshake outputs and register-file next values.
  always_comb begin
    aw_held_d    = aw_held_q | aw_fire_c;
    w_held_d     = w_held_q | w_fire_c;
    awready_d    = 1'b0;
    wready_d     = 1'b0;
    bvalid_d     = 1'b0;
    arready_d    = 1'b0;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    done_d       = done_q;
    start_req_d  = 1'b0;
    core_start_d = start_req_q;
    addr_lo_d    = addr_lo_q;
    addr_hi_d    = addr_hi_q;
    num_d        = num_q;
`ifdef PS_CTRL_IRQ_EN
    gie_d        = gie_q;
    ier_d        = ier_q;
    isr_d        = isr_q;
    irq_d        = gie_q & isr_q;
`endif

    case (w_state_q)
      W_ADDR: begin
        if (wr_en_c) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      // Re-arm the address/data channels on the B handshake edge.
      W_RESP: begin
        bvalid_d  = !b_fire_c;
        awready_d = b_fire_c;
        wready_d  = b_fire_c;
      end
    endcase

    case (r_state_q)
      R_ADDR: begin
        if (ar_fire_c) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_word_c;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        rvalid_d  = !r_fire_c;
        arready_d = r_fire_c;
      end
    endcase

    if (wr_en_c) begin
      case (wr_idx_c)
        REG_CTRL: start_req_d = wr_strb_c[0] & wr_data_c[0] & core_idle &
                                !start_req_q & !core_start_q;
`ifdef PS_CTRL_IRQ_EN
        REG_GIE:  if (wr_strb_c[0]) gie_d = wr_data_c[0];
        REG_IER:  if (wr_strb_c[0]) ier_d = wr_data_c[0];
        REG_ISR:  if (wr_strb_c[0] && wr_data_c[0]) isr_d = !isr_q;
`endif
        REG_ADDR_LO: addr_lo_d = merge_bytes(addr_lo_q, wr_data_c, wr_strb_c);
        REG_ADDR_HI: addr_hi_d = merge_bytes(addr_hi_q, wr_data_c, wr_strb_c);
        REG_NUM:     num_d     = merge_bytes(num_q, wr_data_c, wr_strb_c);
        default: ;
      endcase
    end

    // Completion set takes priority over clear-on-read / write-to-clear.
    if (ar_fire_c && rd_idx_c == REG_CTRL) done_d = 1'b0;
    if (core_done) done_d = 1'b1;
`ifdef PS_CTRL_IRQ_EN
    if (core_done && ier_q) isr_d = 1'b1;
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      start_req_q  <= 1'b0;
      core_start_q <= 1'b0;
      addr_lo_q    <= '0;
      addr_hi_q    <= '0;
      num_q        <= '0;
`ifdef PS_CTRL_IRQ_EN
      gie_q        <= 1'b0;
      ier_q        <= 1'b0;
      isr_q        <= 1'b0;
      irq_q        <= 1'b0;
`endif
    end else begin
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      if (aw_fire_c) aw_idx_q <= s_axi_control.awaddr[IDX_LSB +: IDX_W];
      if (w_fire_c) begin
        wdata_q <= s_axi_control.wdata;
        wstrb_q <= s_axi_control.wstrb;
      end
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      start_req_q  <= start_req_d;
      core_start_q <= core_start_d;
      addr_lo_q    <= addr_lo_d;
      addr_hi_q    <= addr_hi_d;
      num_q        <= num_d;
`ifdef PS_CTRL_IRQ_EN
      gie_q        <= gie_d;
      ier_q        <= ier_d;
      isr_q        <= isr_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign s_axi_control.awready = awready_q;
  assign s_axi_control.wready  = wready_q;
  assign s_axi_control.bvalid  = bvalid_q;
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = arready_q;
  assign s_axi_control.rvalid  = rvalid_q;
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = 2'b00;

  assign core_start     = core_start_q;
  assign cfg_instr_addr = {addr_hi_q, addr_lo_q};
  assign cfg_instr_num  = num_q;
`ifdef PS_CTRL_IRQ_EN
  assign interrupt      = irq_q;
`else
  assign interrupt      = 1'b0;
`endif
endmodule

// File: tb/tb_ps_ctrl_regs.sv
// tb_ps_ctrl_regs: directed bench for ps_ctrl_regs with a scoreboard of expected
// read data / write responses. Interrupt expectations follow PS_CTRL_IRQ_EN.
module tb_ps_ctrl_regs;
`ifdef PS_CTRL_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_start;
  logic        core_done;
  logic        core_idle;
  logic [63:0] cfg_instr_addr;
  logic [31:0] cfg_instr_num;
  logic        interrupt;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int s0;

  logic [31:0] exp_r[$];
  logic [1:0]  exp_b[$];

  ps_ctrl_regs_if #(.ADDR_W(12), .DATA_W(32)) axi ();

  ps_ctrl_regs #(
    .PS_CTRL_AXI_ADDR_WIDTH(12),
    .PS_CTRL_AXI_DATA_WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi_control  (axi),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_idle      (core_idle),
    .cfg_instr_addr (cfg_instr_addr),
    .cfg_instr_num  (cfg_instr_num),
    .interrupt      (interrupt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input string tag, input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.wvalid = 1'b1;
    axi.awvalid = (lead == 0);
    while (!(aw_done && w_done) && n < 40) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      @(negedge clk); n++;
      if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  axi.wvalid = 1'b0; end
      if (!aw_done && n >= lead) axi.awvalid = 1'b1;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    check({tag, "_aw_w_accepted"}, 64'(aw_done && w_done), 64'd1);
    exp_b.push_back(2'b00);
  endtask

  task automatic wait_b(input string tag, input int stall);
    int n;
    logic [1:0] e;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 64'(axi.bvalid), 64'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 64'(axi.bvalid), 64'd1);
      check({tag, "_awready_blocked"}, 64'(axi.awready), 64'd0);
    end
    e = exp_b.pop_front();
    check({tag, "_bresp"}, 64'(axi.bresp), 64'(e));
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check({tag, "_bvalid_single"}, 64'(axi.bvalid), 64'd0);
  endtask

  task automatic wr(input string tag, input logic [11:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int lead);
    axi_write(tag, addr, data, strb, lead);
    wait_b(tag, 0);
  endtask

  task automatic axi_read(input string tag, input logic [11:0] addr, input logic [31:0] exp,
                          input int hold, input bit done_at_hs);
    int n;
    bit hs;
    logic [31:0] e;
    exp_r.push_back(exp);
    axi.araddr = addr; axi.arvalid = 1'b1;
    n = 0; hs = 0;
    while (!hs && n < 20) begin
      hs = (axi.arready === 1'b1);
      if (hs && done_at_hs) core_done = 1'b1;
      @(negedge clk); n++;
    end
    axi.arvalid = 1'b0; core_done = 1'b0;
    check({tag, "_ar_hs"}, 64'(hs), 64'd1);
    n = 0;
    while (axi.rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 64'(axi.rvalid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_rvalid_hold"}, 64'(axi.rvalid), 64'd1);
      check({tag, "_rdata_hold"}, 64'(axi.rdata), 64'(exp_r[0]));
    end
    check({tag, "_rresp"}, 64'(axi.rresp), 64'd0);
    e = exp_r.pop_front();
    check(tag, 64'(axi.rdata), 64'(e));
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check({tag, "_rvalid_drop"}, 64'(axi.rvalid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; core_done = 1'b0; core_idle = 1'b1;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
    axi.bready = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 64'(axi.awready), 64'd0);
    check("rst_wready", 64'(axi.wready), 64'd0);
    check("rst_arready", 64'(axi.arready), 64'd0);
    check("rst_bvalid", 64'(axi.bvalid), 64'd0);
    check("rst_rvalid", 64'(axi.rvalid), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_interrupt", 64'(interrupt), 64'd0);
    check("rst_cfg_addr", cfg_instr_addr, 64'd0);
    check("rst_cfg_num", 64'(cfg_instr_num), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 64'(axi.awready), 64'd1);
    check("post_rst_wready", 64'(axi.wready), 64'd1);
    check("post_rst_arready", 64'(axi.arready), 64'd1);
    axi_read("ctrl_after_reset", 12'h000, 32'h4, 0, 0);

    // Configuration writes, W leading AW by 3 cycles
    wr("wr_addr_lo", 12'h010, 32'hDEADBEEF, 4'hF, 3);
    wr("wr_addr_hi", 12'h014, 32'h1, 4'hF, 3);
    wr("wr_num", 12'h018, 32'h40, 4'hF, 3);
    check("cfg_instr_addr", cfg_instr_addr, 64'h1_DEADBEEF);
    check("cfg_instr_num", 64'(cfg_instr_num), 64'h40);
    axi_read("rd_addr_lo", 12'h010, 32'hDEADBEEF, 2, 0);
    axi_read("rd_addr_hi", 12'h014, 32'h1, 0, 0);

    // Byte-strobe masking
    wr("wr_num_strb", 12'h018, 32'hFFFF_FFFF, 4'b0010, 0);
    check("cfg_num_strb", 64'(cfg_instr_num), 64'h0000_FF40);

    // START with core idle, then with core busy
    s0 = start_cnt;
    wr("wr_start_idle", 12'h000, 32'h1, 4'hF, 0);
    repeat (4) @(negedge clk);
    check("start_pulses_idle", 64'(start_cnt - s0), 64'd1);
    core_idle = 1'b0;
    s0 = start_cnt;
    wr("wr_start_busy", 12'h000, 32'h1, 4'hF, 1);
    repeat (4) @(negedge clk);
    check("start_pulses_busy", 64'(start_cnt - s0), 64'd0);
    core_idle = 1'b1;

    // DONE sticky and clear-on-read
    core_done = 1'b1; @(negedge clk); core_done = 1'b0; @(negedge clk);
    axi_read("ctrl_done_set", 12'h000, 32'h6, 0, 0);
    axi_read("ctrl_done_clr", 12'h000, 32'h4, 0, 0);
    // core_done on the CTRL read edge: old value returned, set wins
    axi_read("ctrl_done_race", 12'h000, 32'h4, 0, 1);
    axi_read("ctrl_done_after_race", 12'h000, 32'h6, 0, 0);

    // Interrupt path
    wr("wr_gie", 12'h004, 32'h1, 4'hF, 0);
    wr("wr_ier", 12'h008, 32'h1, 4'hF, 0);
    axi_read("rd_gie", 12'h004, 32'(IRQ), 0, 0);
    axi_read("rd_ier", 12'h008, 32'(IRQ), 0, 0);
    core_done = 1'b1; @(negedge clk); core_done = 1'b0;
    check("irq_after_1", 64'(interrupt), 64'd0);
    @(negedge clk);
    check("irq_after_2", 64'(interrupt), 64'(IRQ));
    axi_read("rd_isr_set", 12'h00C, 32'(IRQ), 0, 0);
    wr("wr_isr_clr", 12'h00C, 32'h1, 4'hF, 0);
    check("irq_cleared", 64'(interrupt), 64'd0);
    axi_read("rd_isr_clr", 12'h00C, 32'h0, 0, 0);
    axi_read("ctrl_done_irq", 12'h000, 32'h6, 0, 0);

    // Unmapped offsets
    axi_read("rd_unmapped_3c", 12'h03C, 32'h0, 0, 0);
    wr("wr_unmapped_1c", 12'h01C, 32'hFFFF_FFFF, 4'hF, 0);
    axi_read("rd_unmapped_1c", 12'h01C, 32'h0, 0, 0);

    // B channel back-pressure
    axi_write("wr_stall", 12'h018, 32'h80, 4'hF, 0);
    wait_b("wr_stall", 5);
    check("cfg_num_stall", 64'(cfg_instr_num), 64'h80);

    // Reset in the middle of a write
    axi.awaddr = 12'h018; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bvalid", 64'(axi.bvalid), 64'd0);
    check("midrst_awready", 64'(axi.awready), 64'd0);
    check("midrst_cfg_num", 64'(cfg_instr_num), 64'd0);
    check("midrst_cfg_addr", cfg_instr_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    wr("wr_after_midrst", 12'h018, 32'h7, 4'hF, 2);
    check("cfg_num_after_midrst", 64'(cfg_instr_num), 64'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
